// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: FSM states, source codes,
// and the tie counter ceiling.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } wb_state_e;

  // Source codes, also used as the value of the last-grant pointer
  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam logic [7:0] TIE_MAX = 8'hFF;

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// Two-way round-robin picker. req[1] is source A, req[0] is source B.
// On a tie the source that was not granted last wins.
module rr_pick2
  import wb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Single requester wins outright; a tie goes to the other side of 'last'
  always_comb begin
    gnt = '0;
    case (req)
      2'b10:   gnt = 2'b10;
      2'b01:   gnt = 2'b01;
      2'b11:   gnt = (last == SRC_A) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two register-file write sources into one
// registered write port with round-robin priority and a tie counter.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              wb_sel,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [7:0]        tie_cnt
);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic              r_last;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_tie;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_tie;

  // Requests are masked while the register file is held or in reset
  assign w_req = {a_valid, b_valid} & {2{~hold & ~rst}};
  assign w_tie = a_valid & b_valid & ~hold;

  rr_pick2 u_pick (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign a_ready = w_gnt[1];
  assign b_ready = w_gnt[0];

  // State register: which source's write is issuing this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state follows this cycle's grant regardless of current state
  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt[1])      w_state_nxt = WR_A;
    else if (w_gnt[0]) w_state_nxt = WR_B;
  end

  // Output stage and priority pointer; both move only on a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= SRC_B;
      r_sel  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_gnt[1]) begin
      r_last <= SRC_A;
      r_sel  <= SRC_A;
      r_addr <= a_addr;
      r_data <= a_data;
    end else if (w_gnt[0]) begin
      r_last <= SRC_B;
      r_sel  <= SRC_B;
      r_addr <= b_addr;
      r_data <= b_data;
    end
  end

  // Saturating count of cycles where both sources competed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_tie <= '0;
    else if (w_tie && r_tie != TIE_MAX) r_tie <= r_tie + 8'd1;
  end

  // Writes to register 0 are accepted but never strobed
  assign wb_we   = (r_state != IDLE) && (r_addr != '0);
  assign wb_sel  = r_sel;
  assign wb_addr = r_addr;
  assign wb_data = r_data;
  assign tie_cnt = r_tie;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a driver applies directed and random
// stimulus, predicts ready and next-cycle write-port contents from the
// arbitration rules, and queues them; a monitor pops and compares.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, wb_sel, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [7:0]  tie_cnt;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          sel;
    int          tie;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: who won last, what the write port currently shows
  bit          m_last_a;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_sel;
  int          m_tie;

  wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .wb_sel(wb_sel), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_last_a = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_sel = 1'b0;
    m_tie = 0;
  endtask

  // One cycle of stimulus, applied away from the rising edge
  task automatic drive(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd, input bit h);
    bit ga, gb, we;
    exp_t e;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; hold = h;
    #1;
    ga = 0; gb = 0; we = 0;
    if (!r && !h) begin
      if (av && bv) begin
        if (m_last_a) gb = 1; else ga = 1;
      end else begin
        ga = av;
        gb = bv;
      end
    end
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (r) begin
      chk("wb_we_in_reset", wb_we, 0);
      model_reset();
    end else begin
      if (av && bv && !h && m_tie < 255) m_tie++;
      if (ga) begin
        m_last_a = 1; m_addr = aa; m_data = ad; m_sel = 1; we = (aa != 0);
      end else if (gb) begin
        m_last_a = 0; m_addr = ba; m_data = bd; m_sel = 0; we = (ba != 0);
      end
    end
    e.we = we; e.addr = m_addr; e.data = m_data; e.sel = m_sel; e.tie = m_tie;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  // Monitor: the write port is compared once per cycle, just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_we", wb_we, e.we);
        chk("wb_addr", wb_addr, e.addr);
        chk("wb_data", wb_data, e.data);
        chk("wb_sel", wb_sel, e.sel);
        chk("tie_cnt", tie_cnt, e.tie[7:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    drive(1, 0, '0, '0, 0, '0, '0, 0);
    drive(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 0);   // ready must stay low in reset
    idle(1);

    // Single A write
    drive(0, 1, 5'd8, 32'h1234, 0, '0, '0, 0);
    idle(2);

    // Fresh reset, then four ties alternate A,B,A,B
    drive(1, 0, '0, '0, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 5'd3, 32'hA0 + i, 1, 5'd4, 32'hB0 + i, 0);
    idle(1);

    // B write to register 0: accepted, not strobed; next tie goes to A
    drive(0, 0, '0, '0, 1, 5'd0, 32'hFFFF, 0);
    drive(0, 1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0);
    idle(1);

    // Same address under hold: nothing during hold, then A then B
    drive(1, 0, '0, '0, 0, '0, '0, 0);
    drive(0, 1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 1);
    drive(0, 1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 1);
    drive(0, 1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 0);
    drive(0, 0, 5'd9, 32'hA, 1, 5'd9, 32'hB, 0);
    idle(2);

    // Hold raised while a write is already registered
    drive(0, 1, 5'd12, 32'hC, 0, '0, '0, 0);
    drive(0, 1, 5'd13, 32'hD, 1, 5'd14, 32'hE, 1);
    drive(0, 0, '0, '0, 1, 5'd14, 32'hE, 0);

    // Reset right after an A acceptance discards the pending write
    drive(0, 1, 5'd10, 32'h55, 0, '0, '0, 0);
    drive(1, 0, '0, '0, 0, '0, '0, 0);
    drive(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0);
    idle(1);

    // Continuous ties past saturation
    for (int i = 0; i < 300; i++) drive(0, 1, 5'd20, i, 1, 5'd21, ~i, 0);
    idle(1);

    // Random traffic, including valid drops, hold and occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            $urandom,
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            $urandom,
            ($urandom_range(0, 7) == 0));
    end
    idle(2);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
